// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding, parity modes and parity helpers
package uart_pkg;

  typedef logic [2:0] uart_state_t;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  typedef logic [1:0] parity_mode_t;

  // Mode 2'b11 is not named: it behaves exactly like PAR_NONE.
  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  function automatic logic parity_enabled(parity_mode_t mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

  // Payload is zero-extended to 9 bits; the extra zeros do not change the XOR.
  function automatic logic parity_bit(logic [8:0] data, parity_mode_t mode);
    return (^data) ^ (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_tx_framer_if.sv
// rtl/uart_tx_framer_if.sv - word handshake and frame configuration into the TX framer
interface uart_tx_framer_if #(
  parameter int DATA_BITS = 8
);
  import uart_pkg::*;

  logic                 tx_valid;
  logic [DATA_BITS-1:0] tx_data;
  parity_mode_t         parity_mode;
  logic                 two_stop;
  logic                 tx_ready;

  modport master (
    output tx_valid,
    output tx_data,
    output parity_mode,
    output two_stop,
    input  tx_ready
  );

  modport slave (
    input  tx_valid,
    input  tx_data,
    input  parity_mode,
    input  two_stop,
    output tx_ready
  );

endinterface

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - bit-cell counter with restart and end-of-cell pulse
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 2,
  parameter int CNT_W        = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic bit_end
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  assign bit_end = !restart && (cnt == LAST);

  // Count 0..CLKS_PER_BIT-1 and wrap; held at 0 while restart is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (restart || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_framer.sv
// rtl/uart_tx_framer.sv - LSB-first UART transmit framer with parity and 1/2 stop bits
module uart_tx_framer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 2,
  parameter int CNT_W        = 8,
  parameter int DATA_BITS    = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  uart_tx_framer_if.slave tx_if,
  output logic            tx_serial,
  output logic            tx_busy,
  output logic            tx_done
);

  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  uart_state_t          state, state_d;
  logic [DATA_BITS-1:0] data_q;
  parity_mode_t         mode_q;
  logic                 two_stop_q;
  logic [IDX_W-1:0]     bit_idx, bit_idx_d;
  logic                 stop_idx, stop_idx_d;
  logic                 ready_q;
  logic                 serial_d;
  logic                 accept;
  logic                 timer_restart;
  logic                 bit_end;

  assign accept         = tx_if.tx_valid && ready_q;
  assign tx_if.tx_ready = ready_q;
  // Timer sits at zero outside a frame so the start cell is always full length.
  assign timer_restart  = (state == ST_IDLE) || (state == ST_DONE);

  uart_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .CNT_W        (CNT_W)
  ) u_bit_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (timer_restart),
    .bit_end (bit_end)
  );

  // Next state plus data-bit and stop-bit indices.
  always_comb begin
    state_d    = state;
    bit_idx_d  = bit_idx;
    stop_idx_d = stop_idx;
    case (state)
      ST_IDLE, ST_DONE: state_d = accept ? ST_START : ST_IDLE;
      ST_START: if (bit_end) state_d = ST_DATA;
      ST_DATA: begin
        if (bit_end) begin
          if (bit_idx == LAST_IDX) begin
            bit_idx_d = '0;
            state_d   = parity_enabled(mode_q) ? ST_PARITY : ST_STOP;
          end else begin
            bit_idx_d = bit_idx + 1'b1;
          end
        end
      end
      ST_PARITY: if (bit_end) state_d = ST_STOP;
      ST_STOP: begin
        if (bit_end) begin
          if (two_stop_q && !stop_idx) begin
            stop_idx_d = 1'b1;
          end else begin
            stop_idx_d = 1'b0;
            state_d    = ST_DONE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Line level for the upcoming cycle, registered below so tx_serial is glitch-free.
  always_comb begin
    case (state_d)
      ST_START:  serial_d = 1'b0;
      ST_DATA:   serial_d = data_q[bit_idx_d];
      ST_PARITY: serial_d = parity_bit(9'(data_q), mode_q);
      default:   serial_d = 1'b1;
    endcase
  end

  // State, indices and all status outputs registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      bit_idx   <= '0;
      stop_idx  <= 1'b0;
      ready_q   <= 1'b0;
      tx_serial <= 1'b1;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      state     <= state_d;
      bit_idx   <= bit_idx_d;
      stop_idx  <= stop_idx_d;
      ready_q   <= (state_d == ST_IDLE) || (state_d == ST_DONE);
      tx_serial <= serial_d;
      tx_busy   <= (state_d != ST_IDLE) && (state_d != ST_DONE);
      tx_done   <= (state_d == ST_DONE);
    end
  end

  // Shadow copies of word and frame config, captured only on an accepted handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q     <= '0;
      mode_q     <= PAR_NONE;
      two_stop_q <= 1'b0;
    end else if (accept) begin
      data_q     <= tx_if.tx_data;
      mode_q     <= tx_if.parity_mode;
      two_stop_q <= tx_if.two_stop;
    end
  end

endmodule

// File: tb/tb_uart_tx_framer.sv
// tb/tb_uart_tx_framer.sv - scoreboard bench for uart_tx_framer
module tb_uart_tx_framer;
  import uart_pkg::*;

  localparam int CPB = 4;
  localparam int DB  = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tx_serial, tx_busy, tx_done;
  logic tx_serial1, tx_busy1, tx_done1;

  int vectors = 0;
  int miscompares = 0;

  // Entry per line cycle: {is_done_cycle, expected tx_serial}
  logic [1:0] exp_q[$];

  uart_tx_framer_if #(.DATA_BITS(DB)) tx_if ();
  uart_tx_framer_if #(.DATA_BITS(DB)) tx_if1 ();

  uart_tx_framer #(.CLKS_PER_BIT(CPB), .CNT_W(8), .DATA_BITS(DB)) dut (
    .clk(clk), .rst_n(rst_n), .tx_if(tx_if),
    .tx_serial(tx_serial), .tx_busy(tx_busy), .tx_done(tx_done)
  );

  uart_tx_framer #(.CLKS_PER_BIT(1), .CNT_W(8), .DATA_BITS(DB)) dut1 (
    .clk(clk), .rst_n(rst_n), .tx_if(tx_if1),
    .tx_serial(tx_serial1), .tx_busy(tx_busy1), .tx_done(tx_done1)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void push_frame(logic [DB-1:0] data, logic [1:0] mode, logic two, int cpb);
    logic par;
    par = (^data) ^ (mode == 2'b10);
    for (int k = 0; k < cpb; k++) exp_q.push_back(2'b00);
    for (int i = 0; i < DB; i++)
      for (int k = 0; k < cpb; k++) exp_q.push_back({1'b0, data[i]});
    if (mode == 2'b01 || mode == 2'b10)
      for (int k = 0; k < cpb; k++) exp_q.push_back({1'b0, par});
    for (int k = 0; k < cpb * (two ? 2 : 1); k++) exp_q.push_back(2'b01);
    exp_q.push_back(2'b11);
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    tx_if.tx_valid = 1'b0;  tx_if.tx_data = '0;  tx_if.parity_mode = 2'b00;  tx_if.two_stop = 1'b0;
    tx_if1.tx_valid = 1'b0; tx_if1.tx_data = '0; tx_if1.parity_mode = 2'b00; tx_if1.two_stop = 1'b0;
    repeat (3) @(negedge clk);
    vectors++; if (tx_serial !== 1'b1) begin miscompares++; $display("FAIL reset_serial: got %b want 1", tx_serial); end
    vectors++; if (tx_if.tx_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready: got %b want 0", tx_if.tx_ready); end
    vectors++; if (tx_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", tx_busy); end
    vectors++; if (tx_done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", tx_done); end
    rst_n = 1'b1;
    @(negedge clk);
    vectors++; if (tx_if.tx_ready !== 1'b1) begin miscompares++; $display("FAIL release_ready: got %b want 1", tx_if.tx_ready); end
    vectors++; if (tx_if1.tx_ready !== 1'b1) begin miscompares++; $display("FAIL release_ready1: got %b want 1", tx_if1.tx_ready); end
  endtask

  task automatic test_frame(string name, logic [DB-1:0] data, logic [1:0] mode, logic two,
                            int exp_len, bit change_mid);
    int cyc;
    logic [1:0] e;
    @(negedge clk);
    tx_if.tx_data = data; tx_if.parity_mode = mode; tx_if.two_stop = two; tx_if.tx_valid = 1'b1;
    push_frame(data, mode, two, CPB);
    @(posedge clk);
    cyc = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      cyc++;
      tx_if.tx_valid = 1'b0;
      if (change_mid && cyc == exp_len / 2) begin
        tx_if.tx_data = ~data; tx_if.parity_mode = mode ^ 2'b11; tx_if.two_stop = ~two;
      end
      e = exp_q.pop_front();
      vectors++; if (tx_serial !== e[0]) begin miscompares++; $display("FAIL %s serial cyc %0d: got %b want %b", name, cyc, tx_serial, e[0]); end
      vectors++; if (tx_done !== e[1]) begin miscompares++; $display("FAIL %s done cyc %0d: got %b want %b", name, cyc, tx_done, e[1]); end
      vectors++; if (tx_busy !== ~e[1]) begin miscompares++; $display("FAIL %s busy cyc %0d: got %b want %b", name, cyc, tx_busy, ~e[1]); end
      vectors++; if (tx_if.tx_ready !== e[1]) begin miscompares++; $display("FAIL %s ready cyc %0d: got %b want %b", name, cyc, tx_if.tx_ready, e[1]); end
      if (tx_done === 1'b1) begin
        vectors++; if (cyc !== exp_len + 1) begin miscompares++; $display("FAIL %s done_cycle: got %0d want %0d", name, cyc, exp_len + 1); end
      end
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    int done_cnt;
    logic [1:0] e;
    @(negedge clk);
    tx_if.tx_data = 8'h11; tx_if.parity_mode = 2'b00; tx_if.two_stop = 1'b0; tx_if.tx_valid = 1'b1;
    push_frame(8'h11, 2'b00, 1'b0, CPB);
    push_frame(8'h22, 2'b00, 1'b0, CPB);
    @(posedge clk);
    cyc = 0;
    done_cnt = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) tx_if.tx_data = 8'h22;
      if (done_cnt == 1 && cyc == 42) tx_if.tx_valid = 1'b0;
      e = exp_q.pop_front();
      vectors++; if (tx_serial !== e[0]) begin miscompares++; $display("FAIL b2b serial cyc %0d: got %b want %b", cyc, tx_serial, e[0]); end
      vectors++; if (tx_done !== e[1]) begin miscompares++; $display("FAIL b2b done cyc %0d: got %b want %b", cyc, tx_done, e[1]); end
      vectors++; if (tx_if.tx_ready !== e[1]) begin miscompares++; $display("FAIL b2b ready cyc %0d: got %b want %b", cyc, tx_if.tx_ready, e[1]); end
      if (tx_done === 1'b1) begin
        done_cnt++;
        vectors++; if (cyc !== done_cnt * 41) begin miscompares++; $display("FAIL b2b done_cycle %0d: got %0d want %0d", done_cnt, cyc, done_cnt * 41); end
      end
    end
    tx_if.tx_valid = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    @(negedge clk);
    tx_if.tx_data = 8'hA5; tx_if.parity_mode = 2'b00; tx_if.two_stop = 1'b0; tx_if.tx_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tx_if.tx_valid = 1'b0;
    repeat (17) @(negedge clk);
    vectors++; if (tx_serial !== 1'b0) begin miscompares++; $display("FAIL midrst_bit3: got %b want 0", tx_serial); end
    vectors++; if (tx_busy !== 1'b1) begin miscompares++; $display("FAIL midrst_busy_before: got %b want 1", tx_busy); end
    rst_n = 1'b0;
    #1;
    vectors++; if (tx_serial !== 1'b1) begin miscompares++; $display("FAIL midrst_serial: got %b want 1", tx_serial); end
    vectors++; if (tx_busy !== 1'b0) begin miscompares++; $display("FAIL midrst_busy: got %b want 0", tx_busy); end
    vectors++; if (tx_if.tx_ready !== 1'b0) begin miscompares++; $display("FAIL midrst_ready: got %b want 0", tx_if.tx_ready); end
    vectors++; if (tx_done !== 1'b0) begin miscompares++; $display("FAIL midrst_done: got %b want 0", tx_done); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vectors++; if (tx_if.tx_ready !== 1'b1) begin miscompares++; $display("FAIL midrst_release_ready: got %b want 1", tx_if.tx_ready); end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      vectors++; if (tx_done !== 1'b0 || tx_serial !== 1'b1) begin miscompares++; $display("FAIL midrst_quiet cyc %0d: done %b serial %b want 0 1", i, tx_done, tx_serial); end
    end
  endtask

  task automatic test_clk1();
    int cyc;
    logic [1:0] e;
    @(negedge clk);
    tx_if1.tx_data = 8'h5A; tx_if1.parity_mode = 2'b10; tx_if1.two_stop = 1'b1; tx_if1.tx_valid = 1'b1;
    push_frame(8'h5A, 2'b10, 1'b1, 1);
    @(posedge clk);
    cyc = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      cyc++;
      tx_if1.tx_valid = 1'b0;
      e = exp_q.pop_front();
      vectors++; if (tx_serial1 !== e[0]) begin miscompares++; $display("FAIL cpb1 serial cyc %0d: got %b want %b", cyc, tx_serial1, e[0]); end
      vectors++; if (tx_done1 !== e[1]) begin miscompares++; $display("FAIL cpb1 done cyc %0d: got %b want %b", cyc, tx_done1, e[1]); end
      vectors++; if (tx_busy1 !== ~e[1]) begin miscompares++; $display("FAIL cpb1 busy cyc %0d: got %b want %b", cyc, tx_busy1, ~e[1]); end
    end
    vectors++; if (cyc !== 13) begin miscompares++; $display("FAIL cpb1 length: got %0d want 13", cyc); end
  endtask

  initial begin
    test_reset();
    test_frame("8n1_a5", 8'hA5, 2'b00, 1'b0, 40, 1'b0);
    test_frame("even_07", 8'h07, 2'b01, 1'b0, 44, 1'b0);
    test_frame("odd_07", 8'h07, 2'b10, 1'b0, 44, 1'b0);
    test_frame("mode11_07", 8'h07, 2'b11, 1'b0, 40, 1'b0);
    test_frame("8n2_00", 8'h00, 2'b00, 1'b1, 44, 1'b0);
    test_frame("midchg_c3", 8'hC3, 2'b01, 1'b1, 48, 1'b1);
    test_back_to_back();
    test_reset_mid_frame();
    test_frame("after_reset", 8'h3C, 2'b10, 1'b0, 44, 1'b0);
    test_clk1();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
